// File: rtl/lz_mult_ctrl.sv
// Sequencer for the leading-zero-stripping approximate multiplier: normalises A then B, captures them, runs the multiplier.
// Optional build macro LZ_MULT_CTRL_ZERO_BYPASS_EN: a zero operand ends the operation early and raises zero in DONE.
module lz_mult_ctrl #(
    parameter int N         = 16,
    parameter int M         = 3,
    parameter int MAX_SHIFT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       op_msb,
    input  logic       mult_done,
    output logic       ld_op,
    output logic       sel_op,
    output logic       shift_en,
    output logic [M:0] cnt,
    output logic       en_a,
    output logic       en_b,
    output logic       mult_start,
    output logic       busy,
    output logic       done,
    output logic       zero
);

    if (MAX_SHIFT > N - 1 || MAX_SHIFT > (1 << (M + 1)) - 1) begin : g_param_check
        $error("lz_mult_ctrl: MAX_SHIFT exceeds shifter width or count range");
    end

    localparam logic [M:0] CNT_MAX = (M + 1)'(MAX_SHIFT);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD_A, S_NORM_A, S_STORE_A,
        S_LOAD_B, S_NORM_B, S_STORE_B, S_MULT, S_WAIT, S_DONE
    } state_t;

    state_t     state, state_nxt;
    logic [M:0] cnt_nxt;

`ifdef LZ_MULT_CTRL_ZERO_BYPASS_EN
    logic zero_op, zero_op_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) zero_op <= 1'b0;
        else      zero_op <= zero_op_nxt;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        ld_op      = 1'b0;
        sel_op     = 1'b0;
        shift_en   = 1'b0;
        en_a       = 1'b0;
        en_b       = 1'b0;
        mult_start = 1'b0;
        done       = 1'b0;
        zero       = 1'b0;
        busy       = (state != S_IDLE);
`ifdef LZ_MULT_CTRL_ZERO_BYPASS_EN
        zero_op_nxt = zero_op;
`endif
        case (state)
            S_IDLE: if (start) state_nxt = S_LOAD_A;
            S_LOAD_A, S_LOAD_B: begin
                ld_op     = 1'b1;
                sel_op    = (state == S_LOAD_B);
                cnt_nxt   = '0;
                state_nxt = (state == S_LOAD_A) ? S_NORM_A : S_NORM_B;
`ifdef LZ_MULT_CTRL_ZERO_BYPASS_EN
                if (state == S_LOAD_A) zero_op_nxt = 1'b0;
`endif
            end
            // shift_en is gated by op_msb so the exit cycle never disturbs the normalised value
            S_NORM_A, S_NORM_B: begin
                sel_op = (state == S_NORM_B);
                if (!op_msb && cnt < CNT_MAX) begin
                    shift_en = 1'b1;
                    cnt_nxt  = cnt + 1'b1;
                end else begin
                    state_nxt = (state == S_NORM_A) ? S_STORE_A : S_STORE_B;
`ifdef LZ_MULT_CTRL_ZERO_BYPASS_EN
                    zero_op_nxt = !op_msb;
`endif
                end
            end
            S_STORE_A: begin
                en_a      = 1'b1;
                state_nxt = S_LOAD_B;
`ifdef LZ_MULT_CTRL_ZERO_BYPASS_EN
                if (zero_op) state_nxt = S_DONE;
`endif
            end
            S_STORE_B: begin
                en_b      = 1'b1;
                sel_op    = 1'b1;
                state_nxt = S_MULT;
`ifdef LZ_MULT_CTRL_ZERO_BYPASS_EN
                if (zero_op) state_nxt = S_DONE;
`endif
            end
            S_MULT: begin
                mult_start = 1'b1;
                state_nxt  = S_WAIT;
            end
            S_WAIT: if (mult_done) state_nxt = S_DONE;
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
`ifdef LZ_MULT_CTRL_ZERO_BYPASS_EN
                zero = zero_op;
`endif
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule
